// File: rtl/rect_draw_sched.sv
// Round-robin rectangle fill scheduler: serves one of three requesters and
// emits its rectangle as a row-major stream of pixel writes.
module rect_draw_sched #(
    parameter int unsigned COLOUR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [23:0]           rect_x,
    input  logic [23:0]           rect_y,
    input  logic [23:0]           rect_w,
    input  logic [23:0]           rect_h,
    input  logic [3*COLOUR_W-1:0] rect_colour,
    output logic [2:0]            grant,
    output logic [2:0]            done,
    output logic [7:0]            x_out,
    output logic [7:0]            y_out,
    output logic [COLOUR_W-1:0]   colour_out,
    output logic                  plot,
    output logic                  busy
);

    localparam int unsigned N_REQ = 3;
    localparam int unsigned CRD_W = 8;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    state_t              state, state_n;
    logic [1:0]          sel, sel_n;
    logic [1:0]          last_served, last_served_n;
    logic [CRD_W-1:0]    sx, sx_n, sy, sy_n, w, w_n, h, h_n;
    logic [CRD_W-1:0]    cx, cx_n, cy, cy_n;
    logic [COLOUR_W-1:0] col, col_n;
    logic [2:0]          grant_n, done_n;
    logic [CRD_W-1:0]    x_out_n, y_out_n;
    logic [COLOUR_W-1:0] colour_out_n;
    logic                plot_n, busy_n;

    logic [CRD_W-1:0]    x_arr [N_REQ];
    logic [CRD_W-1:0]    y_arr [N_REQ];
    logic [CRD_W-1:0]    w_arr [N_REQ];
    logic [CRD_W-1:0]    h_arr [N_REQ];
    logic [COLOUR_W-1:0] c_arr [N_REQ];

    logic [1:0] start, pick;
    logic [2:0] cand;
    logic       found;
    logic       last_col, last_row;

    // Unpack the flat per-requester buses
    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            x_arr[i] = rect_x[CRD_W*i +: CRD_W];
            y_arr[i] = rect_y[CRD_W*i +: CRD_W];
            w_arr[i] = rect_w[CRD_W*i +: CRD_W];
            h_arr[i] = rect_h[CRD_W*i +: CRD_W];
            c_arr[i] = rect_colour[COLOUR_W*i +: COLOUR_W];
        end
    end

    // Round-robin search starting just after the last served requester
    always_comb begin
        start = (last_served == 2'd2) ? 2'd0 : last_served + 2'd1;
        pick  = 2'd0;
        found = 1'b0;
        cand  = 3'd0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = 3'(start) + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!found && req[cand[1:0]]) begin
                found = 1'b1;
                pick  = cand[1:0];
            end
        end
    end

    assign last_col = (cx == w - 8'd1);
    assign last_row = (cy == h - 8'd1);

    // Next-state and registered-output logic
    always_comb begin
        state_n       = state;
        sel_n         = sel;
        last_served_n = last_served;
        sx_n          = sx;
        sy_n          = sy;
        w_n           = w;
        h_n           = h;
        col_n         = col;
        cx_n          = cx;
        cy_n          = cy;
        grant_n       = grant;
        done_n        = 3'b000;
        plot_n        = 1'b0;
        x_out_n       = x_out;
        y_out_n       = y_out;
        colour_out_n  = colour_out;

        unique case (state)
            IDLE: begin
                if (found) begin
                    sel_n   = pick;
                    sx_n    = x_arr[pick];
                    sy_n    = y_arr[pick];
                    w_n     = w_arr[pick];
                    h_n     = h_arr[pick];
                    col_n   = c_arr[pick];
                    cx_n    = '0;
                    cy_n    = '0;
                    grant_n = 3'b001 << pick;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (w == '0 || h == '0) begin
                    done_n[sel] = 1'b1;
                    state_n     = DONE;
                end else begin
                    plot_n       = 1'b1;
                    x_out_n      = sx;
                    y_out_n      = sy;
                    colour_out_n = col;
                    state_n      = DRAW;
                end
            end
            DRAW: begin
                if (last_col && last_row) begin
                    done_n[sel] = 1'b1;
                    state_n     = DONE;
                end else begin
                    if (last_col) begin
                        cx_n = '0;
                        cy_n = cy + 8'd1;
                    end else begin
                        cx_n = cx + 8'd1;
                    end
                    plot_n  = 1'b1;
                    x_out_n = sx + cx_n;
                    y_out_n = sy + cy_n;
                end
            end
            DONE: begin
                last_served_n = sel;
                grant_n       = 3'b000;
                state_n       = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= 2'd0;
            last_served <= 2'd2;
            sx          <= '0;
            sy          <= '0;
            w           <= '0;
            h           <= '0;
            col         <= '0;
            cx          <= '0;
            cy          <= '0;
            grant       <= 3'b000;
            done        <= 3'b000;
            plot        <= 1'b0;
            busy        <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            colour_out  <= '0;
        end else begin
            state       <= state_n;
            sel         <= sel_n;
            last_served <= last_served_n;
            sx          <= sx_n;
            sy          <= sy_n;
            w           <= w_n;
            h           <= h_n;
            col         <= col_n;
            cx          <= cx_n;
            cy          <= cy_n;
            grant       <= grant_n;
            done        <= done_n;
            plot        <= plot_n;
            busy        <= busy_n;
            x_out       <= x_out_n;
            y_out       <= y_out_n;
            colour_out  <= colour_out_n;
        end
    end

endmodule

// File: tb/tb_rect_draw_sched.sv
// Directed self-checking bench for rect_draw_sched.
module tb_rect_draw_sched;

    localparam int unsigned COLOUR_W = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [2:0]            req;
    logic [23:0]           rect_x, rect_y, rect_w, rect_h;
    logic [3*COLOUR_W-1:0] rect_colour;
    logic [2:0]            grant, done;
    logic [7:0]            x_out, y_out;
    logic [COLOUR_W-1:0]   colour_out;
    logic                  plot, busy;

    int checks   = 0;
    int failures = 0;

    rect_draw_sched #(.COLOUR_W(COLOUR_W)) dut (
        .clk(clk), .reset(reset), .req(req),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .rect_colour(rect_colour),
        .grant(grant), .done(done), .x_out(x_out), .y_out(y_out),
        .colour_out(colour_out), .plot(plot), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_rect(input int i, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] w, input logic [7:0] h,
                            input logic [COLOUR_W-1:0] c);
        rect_x[8*i +: 8] = x;
        rect_y[8*i +: 8] = y;
        rect_w[8*i +: 8] = w;
        rect_h[8*i +: 8] = h;
        rect_colour[COLOUR_W*i +: COLOUR_W] = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 3'b000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [7:0] exp_x [6];
    logic [7:0] exp_y [6];
    logic [2:0] exp_g [4];
    int         nplot;

    initial begin
        rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; rect_colour = '0;
        do_reset();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_xy", {16'd0, x_out, y_out}, 32'd0);
        chk("rst_col", 32'(colour_out), 32'd0);

        // 3x2 rectangle from requester 0
        set_rect(0, 8'd10, 8'd20, 8'd3, 8'd2, 3'd5);
        req = 3'b001;
        tick();
        chk("r1_load_busy", 32'(busy), 32'd1);
        chk("r1_load_grant", 32'(grant), 32'b001);
        chk("r1_load_plot", 32'(plot), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("r1_plot", 32'(plot), 32'd1);
            chk("r1_x", 32'(x_out), 32'(10 + (i % 3)));
            chk("r1_y", 32'(y_out), 32'(20 + (i / 3)));
            chk("r1_col", 32'(colour_out), 32'd5);
            chk("r1_done_low", 32'(done), 32'd0);
        end
        tick();
        chk("r1_done", 32'(done), 32'b001);
        chk("r1_done_plot", 32'(plot), 32'd0);
        chk("r1_done_grant", 32'(grant), 32'b001);
        tick();
        chk("r1_idle_done", 32'(done), 32'd0);
        chk("r1_idle_grant", 32'(grant), 32'd0);
        chk("r1_idle_busy", 32'(busy), 32'd0);
        req = 3'b000;
        tick();
        chk("r1_no_regrant", 32'(busy), 32'd0);

        // Round robin with all requests held
        do_reset();
        set_rect(0, 8'd1, 8'd0, 8'd1, 8'd1, 3'd1);
        set_rect(1, 8'd2, 8'd0, 8'd1, 8'd1, 3'd2);
        set_rect(2, 8'd3, 8'd0, 8'd1, 8'd1, 3'd3);
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(exp_g[i]));
            tick();
            chk("rr_plot", 32'(plot), 32'd1);
            chk("rr_x", 32'(x_out), 32'((i % 3) + 1));
            tick();
            chk("rr_plot_off", 32'(plot), 32'd0);
            chk("rr_done", 32'(done), 32'(exp_g[i]));
            tick();
            chk("rr_idle_grant", 32'(grant), 32'd0);
        end
        req = 3'b000;

        // Coordinate wrap
        do_reset();
        set_rect(0, 8'd254, 8'd255, 8'd3, 8'd2, 3'd7);
        exp_x[0] = 8'd254; exp_x[1] = 8'd255; exp_x[2] = 8'd0;
        exp_x[3] = 8'd254; exp_x[4] = 8'd255; exp_x[5] = 8'd0;
        exp_y[0] = 8'd255; exp_y[1] = 8'd255; exp_y[2] = 8'd255;
        exp_y[3] = 8'd0;   exp_y[4] = 8'd0;   exp_y[5] = 8'd0;
        req = 3'b001;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wrap_plot", 32'(plot), 32'd1);
            chk("wrap_x", 32'(x_out), 32'(exp_x[i]));
            chk("wrap_y", 32'(y_out), 32'(exp_y[i]));
        end
        req = 3'b000;
        tick();
        chk("wrap_plot_end", 32'(plot), 32'd0);
        chk("wrap_done", 32'(done), 32'b001);
        tick();

        // Zero width, then zero height
        set_rect(0, 8'd5, 8'd5, 8'd0, 8'd5, 3'd1);
        req = 3'b001;
        tick();
        chk("w0_load_plot", 32'(plot), 32'd0);
        req = 3'b000;
        tick();
        chk("w0_plot", 32'(plot), 32'd0);
        chk("w0_done", 32'(done), 32'b001);
        tick();
        set_rect(2, 8'd5, 8'd5, 8'd4, 8'd0, 3'd1);
        req = 3'b100;
        tick();
        chk("h0_grant", 32'(grant), 32'b100);
        chk("h0_load_plot", 32'(plot), 32'd0);
        req = 3'b000;
        tick();
        chk("h0_plot", 32'(plot), 32'd0);
        chk("h0_done", 32'(done), 32'b100);
        tick();

        // Reset during the third plot of a 4x4 rectangle
        do_reset();
        set_rect(0, 8'd30, 8'd40, 8'd4, 8'd4, 3'd2);
        set_rect(1, 8'd7, 8'd8, 8'd1, 8'd1, 3'd6);
        req = 3'b001;
        tick();
        tick();
        tick();
        tick();
        chk("ab_third_x", 32'(x_out), 32'd32);
        reset = 1'b1;
        req   = 3'b000;
        tick();
        chk("ab_plot", 32'(plot), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_grant", 32'(grant), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        reset = 1'b0;
        req   = 3'b010;
        tick();
        chk("ab_next_grant", 32'(grant), 32'b010);
        tick();
        chk("ab_next_plot", 32'(plot), 32'd1);
        chk("ab_next_xy", {16'd0, x_out, y_out}, {16'd0, 8'd7, 8'd8});
        chk("ab_next_col", 32'(colour_out), 32'd6);
        req = 3'b000;
        tick();
        chk("ab_next_done", 32'(done), 32'b010);
        tick();

        // Inputs changing mid-draw leave the rectangle intact
        set_rect(0, 8'd50, 8'd60, 8'd2, 8'd2, 3'd3);
        req = 3'b001;
        tick();
        tick();
        chk("mid_first_x", 32'(x_out), 32'd50);
        req = 3'b000;
        set_rect(0, 8'd99, 8'd99, 8'd9, 8'd9, 3'd0);
        nplot = 1;
        for (int i = 0; i < 20 && done == 3'b000; i++) begin
            tick();
            if (plot) nplot++;
            if (i == 2) begin
                chk("mid_last_xy", {16'd0, x_out, y_out}, {16'd0, 8'd51, 8'd61});
                chk("mid_last_col", 32'(colour_out), 32'd3);
            end
        end
        chk("mid_plot_count", 32'(nplot), 32'd4);
        chk("mid_done", 32'(done), 32'b001);
        tick();
        chk("mid_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
